// File: rtl/mul_ctrl.sv
// Multiply sequencer for the EXE stage: extends operands, waits out the external
// 33x33 signed multiplier pipeline, applies HI/LO accumulation and holds the result.
module mul_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [63:0] req_hilo,
  input  logic        flush,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, CAP, DONE} state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MADDU = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MSUBU = 3'd6;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [32:0] mul_a_q, mul_a_d;
  logic [32:0] mul_b_q, mul_b_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] res_q, res_d;
  logic        res_valid_q, res_valid_d;

  logic        accept;
  logic        sign_ext;
  logic [63:0] prod;
  logic [63:0] acc_res;
  logic        unused_p_hi;

  // The top two product bits only matter for 33-bit operands; results are mod 2^64.
  assign prod        = mul_p[63:0];
  assign unused_p_hi = ^mul_p[65:64];

  assign req_ready = (state_q == IDLE) || ((state_q == DONE) && res_ready);
  assign accept    = req_valid && req_ready && !flush;
  assign sign_ext  = (req_op == OP_MULT) || (req_op == OP_MUL) ||
                     (req_op == OP_MADD) || (req_op == OP_MSUB);

  always_comb begin
    unique case (op_q)
      OP_MADD, OP_MADDU: acc_res = hilo_q + prod;
      OP_MSUB, OP_MSUBU: acc_res = hilo_q - prod;
      default:           acc_res = prod;
    endcase
  end

  // NOTE: every next-state variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    op_d        = op_q;
    hilo_d      = hilo_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      IDLE: ;
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = CAP;
      end
      CAP: begin
        res_d       = acc_res;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance is possible from IDLE or from DONE while the result drains.
    if (accept) begin
      mul_a_d = sign_ext ? {req_src1[31], req_src1} : {1'b0, req_src1};
      mul_b_d = sign_ext ? {req_src2[31], req_src2} : {1'b0, req_src2};
      op_d    = req_op;
      hilo_d  = req_hilo;
      cnt_d   = 3'(LATENCY);
      state_d = WAIT;
    end

    // Flush wins over everything; the next op restarts the full countdown,
    // so a stale product still in the multiplier can never reach CAP.
    if (flush) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
      cnt_d       = 3'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mul_a_q     <= 33'd0;
      mul_b_q     <= 33'd0;
      op_q        <= 3'd0;
      hilo_q      <= 64'd0;
      res_q       <= 64'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      op_q        <= op_d;
      hilo_q      <= hilo_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_hi    = res_q[63:32];
  assign res_lo    = res_q[31:0];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: transaction-level reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_mul_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_src1 = 32'd0;
  logic [31:0] req_src2 = 32'd0;
  logic [63:0] req_hilo = 64'd0;
  logic        flush = 1'b0;
  logic [32:0] mul_a, mul_b;
  logic [65:0] mul_p;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_hi, res_lo;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mul_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_hilo(req_hilo),
    .flush(flush), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: LAT register stages of a signed 33x33 product, never reset.
  logic [65:0] pipe [LAT];
  logic signed [65:0] ext_a, ext_b;
  assign ext_a = {{33{mul_a[32]}}, mul_a};
  assign ext_b = {{33{mul_b[32]}}, mul_b};
  assign mul_p = pipe[LAT-1];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= ext_a * ext_b;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] s1,
                                             input logic [31:0] s2, input logic [63:0] hl);
    logic [63:0] a, b, p;
    logic sgn;
    sgn = (op == 3'd0) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
    a = sgn ? {{32{s1[31]}}, s1} : {32'd0, s1};
    b = sgn ? {{32{s2[31]}}, s2} : {32'd0, s2};
    p = a * b;
    if (op == 3'd3 || op == 3'd4) return hl + p;
    if (op == 3'd5 || op == 3'd6) return hl - p;
    return p;
  endfunction

  // Transaction model: 0 idle, 1 computing (edges left in m_cnt), 2 result held.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (flush) begin
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      logic rdy;
      rdy = (m_phase == 0) || (m_phase == 2 && res_ready);
      if (m_phase == 1) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_phase = 2;
          m_res   = m_pend;
        end
      end else if (m_phase == 2 && res_ready) begin
        m_phase = 0;
      end
      if (rdy && req_valid) begin
        m_phase = 1;
        m_cnt   = LAT + 1;
        m_pend  = ref_result(req_op, req_src1, req_src2, req_hilo);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc_res_valid", 64'(res_valid), 64'(m_phase == 2));
    check("cyc_busy", 64'(busy), 64'(m_phase != 0));
    check("cyc_req_ready", 64'(req_ready), 64'((m_phase == 0) || (m_phase == 2 && res_ready)));
    if (m_phase == 2) check("cyc_result", {res_hi, res_lo}, m_res);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Presents one op from IDLE, checks latency and value, optionally drains it.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [63:0] hl, input logic [63:0] exp,
                        input bit drain);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; req_hilo = hl;
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!res_valid && n < 20);
    check({name, "_latency"}, 64'(n), 64'(LAT + 1));
    check({name, "_value"}, {res_hi, res_lo}, exp);
    if (drain) begin
      @(negedge clk); res_ready = 1'b1;
      @(negedge clk); res_ready = 1'b0;
    end
  endtask

  logic [63:0] held;
  bit          seen_valid;
  int          n2;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_mul_a", 64'(mul_a), 64'd0);
    check("reset_result", {res_hi, res_lo}, 64'd0);
    @(negedge clk); rst = 1'b1;

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 1);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1);
    run_op("mult_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_0000_0001, 1);
    run_op("madd", 3'd3, 32'd4, 32'd5, 64'h10, 64'h0000_0000_0000_0024, 1);
    run_op("msubu_wrap", 3'd6, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("msub", 3'd5, 32'hFFFF_FFFE, 32'd3, 64'd100, 64'd106, 1);
    run_op("maddu", 3'd4, 32'h8000_0000, 32'd2, 64'd1, 64'h0000_0001_0000_0001, 1);
    run_op("rsvd", 3'd7, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h0000_0001_FFFF_FFFE, 1);
    run_op("mul", 3'd2, 32'hFFFF_FFF0, 32'h10, 64'd0, 64'hFFFF_FFFF_FFFF_FF00, 1);

    // Backpressure then back-to-back accept from DONE.
    run_op("bp_first", 3'd1, 32'd9, 32'd9, 64'd0, 64'd81, 0);
    held = {res_hi, res_lo};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 64'(res_valid), 64'd1);
      check("bp_result_held", {res_hi, res_lo}, held);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    res_ready = 1'b1; req_valid = 1'b1; req_op = 3'd1; req_src1 = 32'd3; req_src2 = 32'd4;
    #1 check("bp_req_ready_open", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_accept_busy", 64'(busy), 64'd1);
    check("bp_accept_valid_drop", 64'(res_valid), 64'd0);
    @(negedge clk); res_ready = 1'b0; req_valid = 1'b0;
    n2 = 0;
    do begin
      @(posedge clk); #1; n2++;
    end while (!res_valid && n2 < 20);
    check("bp_second_latency", 64'(n2), 64'(LAT + 1));
    check("bp_second_value", {res_hi, res_lo}, 64'd12);
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;

    // Flush in WAIT with cnt==1: result must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'd11; req_src2 = 32'd11;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush_wait_busy", 64'(busy), 64'd0);
    @(negedge clk); flush = 1'b0;
    seen_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (res_valid) seen_valid = 1'b1;
    end
    check("flush_no_result", 64'(seen_valid), 64'd0);

    // Flush coinciding with a request in IDLE.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check("flush_idle_not_accepted", 64'(busy), 64'd0);
    @(negedge clk); req_valid = 1'b0; flush = 1'b0;

    // Reset while in CAP, then a clean op afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; req_src1 = 32'd1000; req_src2 = 32'd1000;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_cap_valid", 64'(res_valid), 64'd0);
    check("rst_cap_busy", 64'(busy), 64'd0);
    check("rst_cap_req_ready", 64'(req_ready), 64'd1);
    check("rst_cap_mul_a", 64'(mul_a), 64'd0);
    check("rst_cap_mul_b", 64'(mul_b), 64'd0);
    check("rst_cap_result", {res_hi, res_lo}, 64'd0);
    @(negedge clk); rst = 1'b1;
    run_op("post_rst_mult", 3'd0, 32'd7, 32'd6, 64'd0, 64'h0000_0000_0000_002A, 1);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
